// File: rtl/interrupt_pending_unit.sv
// Interrupt pending unit: sw/timer/external sources, enables, time counter.
// Produces the registered, masked 16-bit pending vector for the priority decoder.
module interrupt_pending_unit #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMER_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ext_irq_s,
    input  logic               ext_irq_m,
    input  logic               tick_en,
    input  logic               global_en,
    input  logic               csr_we,
    input  logic [1:0]         csr_sel,
    input  logic [TIMER_W-1:0] csr_wdata,
    output logic [TIMER_W-1:0] csr_rdata,
    output logic [TIMER_W-1:0] mtime,
    output logic [15:0]        irq_signal,
    output logic               irq_valid
);

    logic [TIMER_W-1:0]     r_mtime;
    logic [TIMER_W-1:0]     r_mtimecmp;
    logic [TIMER_W-1:0]     r_stimecmp;
    logic [1:0]             r_sw;
    logic                   r_tmr_s;
    logic                   r_tmr_m;
    logic [SYNC_STAGES-1:0] r_sync_s;
    logic [SYNC_STAGES-1:0] r_sync_m;
    logic [5:0]             r_en;
    logic [15:0]            r_irq;
    logic                   r_valid;

    logic [5:0]             w_pend;
    logic [5:0]             w_masked;
    logic                   w_wr_pend;
    logic                   w_wr_en;
    logic                   w_wr_mcmp;
    logic                   w_wr_scmp;

    assign w_pend = {r_sync_m[SYNC_STAGES-1], r_sync_s[SYNC_STAGES-1],
                     r_tmr_m, r_tmr_s, r_sw};
    assign w_masked = w_pend & r_en & {6{global_en}};

    assign w_wr_pend = csr_we && (csr_sel == 2'd0);
    assign w_wr_en   = csr_we && (csr_sel == 2'd1);
    assign w_wr_mcmp = csr_we && (csr_sel == 2'd2);
    assign w_wr_scmp = csr_we && (csr_sel == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_stimecmp <= '1;
            r_sw       <= '0;
            r_tmr_s    <= 1'b0;
            r_tmr_m    <= 1'b0;
            r_sync_s   <= '0;
            r_sync_m   <= '0;
            r_en       <= '0;
            r_irq      <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (tick_en)
                r_mtime <= r_mtime + TIMER_W'(1);
            if (w_wr_mcmp)
                r_mtimecmp <= csr_wdata;
            if (w_wr_scmp)
                r_stimecmp <= csr_wdata;
            if (w_wr_pend)
                r_sw <= csr_wdata[1:0];
            if (w_wr_en)
                r_en <= csr_wdata[5:0];
            // Compares use the pre-write register values on purpose.
            r_tmr_s  <= (r_mtime >= r_stimecmp);
            r_tmr_m  <= (r_mtime >= r_mtimecmp);
            r_sync_s <= {r_sync_s[SYNC_STAGES-2:0], ext_irq_s};
            r_sync_m <= {r_sync_m[SYNC_STAGES-2:0], ext_irq_m};
            r_irq    <= {10'b0, w_masked};
            r_valid  <= |w_masked;
        end
    end

    always_comb begin
        csr_rdata = '0;
        unique case (csr_sel)
            2'd0: csr_rdata = {{(TIMER_W-6){1'b0}}, w_pend};
            2'd1: csr_rdata = {{(TIMER_W-6){1'b0}}, r_en};
            2'd2: csr_rdata = r_mtimecmp;
            2'd3: csr_rdata = r_stimecmp;
            default: csr_rdata = '0;
        endcase
    end

    assign mtime      = r_mtime;
    assign irq_signal = r_irq;
    assign irq_valid  = r_valid;

endmodule

// File: tb/tb_interrupt_pending_unit.sv
// Bench for interrupt_pending_unit: per-cycle model compare plus directed checks.
// A narrow-timer instance covers the mtime wrap case in a few hundred cycles.
module tb_interrupt_pending_unit;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ext_irq_s, ext_irq_m, tick_en, global_en, csr_we;
    logic [1:0]  csr_sel;
    logic [31:0] csr_wdata, csr_rdata, mtime;
    logic [15:0] irq_signal;
    logic        irq_valid;

    logic        w2_ten, w2_we;
    logic [1:0]  w2_sel;
    logic [7:0]  w2_wd, w2_rd, w2_mtime;
    logic [15:0] w2_irq;
    logic        w2_valid;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    interrupt_pending_unit #(.SYNC_STAGES(N), .TIMER_W(32)) dut (
        .clk(clk), .reset(reset), .ext_irq_s(ext_irq_s), .ext_irq_m(ext_irq_m),
        .tick_en(tick_en), .global_en(global_en), .csr_we(csr_we),
        .csr_sel(csr_sel), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .mtime(mtime), .irq_signal(irq_signal), .irq_valid(irq_valid)
    );

    interrupt_pending_unit #(.SYNC_STAGES(N), .TIMER_W(8)) dut_w (
        .clk(clk), .reset(reset), .ext_irq_s(1'b0), .ext_irq_m(1'b0),
        .tick_en(w2_ten), .global_en(1'b1), .csr_we(w2_we),
        .csr_sel(w2_sel), .csr_wdata(w2_wd), .csr_rdata(w2_rd),
        .mtime(w2_mtime), .irq_signal(w2_irq), .irq_valid(w2_valid)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad < 40)
                $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: architectural state, and ext line history indexed by edge count.
    logic [31:0] m_mtime, m_mcmp, m_scmp;
    logic [1:0]  m_sw;
    logic        m_st, m_mt;
    logic [5:0]  m_en;
    logic [15:0] m_irq;
    int          m_cyc;
    bit          m_hs [8];
    bit          m_hm [8];

    function automatic logic [5:0] m_pend();
        bit es, em;
        es = (m_cyc >= N) ? m_hs[(m_cyc - N) % 8] : 1'b0;
        em = (m_cyc >= N) ? m_hm[(m_cyc - N) % 8] : 1'b0;
        return {em, es, m_mt, m_st, m_sw};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mtime <= 0;
            m_mcmp  <= '1;
            m_scmp  <= '1;
            m_sw    <= 0;
            m_st    <= 0;
            m_mt    <= 0;
            m_en    <= 0;
            m_irq   <= 0;
            m_cyc   <= 0;
        end else begin
            m_irq <= global_en ? {10'b0, m_pend() & m_en} : 16'h0;
            m_st  <= m_mtime >= m_scmp;
            m_mt  <= m_mtime >= m_mcmp;
            if (csr_we && csr_sel == 2'd0) m_sw   <= csr_wdata[1:0];
            if (csr_we && csr_sel == 2'd1) m_en   <= csr_wdata[5:0];
            if (csr_we && csr_sel == 2'd2) m_mcmp <= csr_wdata;
            if (csr_we && csr_sel == 2'd3) m_scmp <= csr_wdata;
            if (tick_en) m_mtime <= m_mtime + 1;
            m_hs[m_cyc % 8] <= ext_irq_s;
            m_hm[m_cyc % 8] <= ext_irq_m;
            m_cyc <= m_cyc + 1;
        end
    end

    function automatic logic [31:0] m_rd(logic [1:0] sel);
        case (sel)
            2'd0: return {26'b0, m_pend()};
            2'd1: return {26'b0, m_en};
            2'd2: return m_mcmp;
            default: return m_scmp;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            chk("mdl_irq", {16'h0, irq_signal}, {16'h0, m_irq});
            chk("mdl_valid", {31'h0, irq_valid}, {31'h0, |m_irq});
            chk("mdl_mtime", mtime, m_mtime);
            chk("mdl_rdata", csr_rdata, m_rd(csr_sel));
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(logic [1:0] sel, logic [31:0] d);
        csr_we = 1'b1;
        csr_sel = sel;
        csr_wdata = d;
        tick();
        csr_we = 1'b0;
        csr_sel = 2'd0;
        csr_wdata = 0;
    endtask

    initial begin
        int i;
        reset = 1'b0;
        {ext_irq_s, ext_irq_m, tick_en, global_en, csr_we} = '0;
        csr_sel = 2'd0;
        csr_wdata = 0;
        {w2_ten, w2_we} = '0;
        w2_sel = 2'd0;
        w2_wd = 0;
        tick(3);
        reset = 1'b1;
        tick();
        chk("rst_irq", {16'h0, irq_signal}, 32'h0);
        chk("rst_mtime", mtime, 32'h0);
        csr_sel = 2'd2;
        #1 chk("rst_mcmp", csr_rdata, 32'hFFFF_FFFF);
        csr_sel = 2'd0;

        // 1: software interrupt
        global_en = 1'b1;
        wr(2'd1, 32'h02);
        wr(2'd0, 32'h02);
        chk("t1_irq_pre", {16'h0, irq_signal}, 32'h0);
        tick();
        chk("t1_irq", {16'h0, irq_signal}, 32'h0002);
        chk("t1_valid", {31'h0, irq_valid}, 32'h1);

        // 2: M-timer
        wr(2'd2, 32'd10);
        wr(2'd1, 32'h08);
        tick_en = 1'b1;
        for (i = 0; i < 40 && mtime != 32'd10; i++) tick();
        chk("t2_reach", mtime, 32'd10);
        chk("t2_irq0", {16'h0, irq_signal}, 32'h0);
        tick();
        chk("t2_pend", csr_rdata, 32'h0A);
        tick();
        chk("t2_irq", {16'h0, irq_signal}, 32'h0008);
        wr(2'd2, 32'hFFFF_FFFF);
        chk("t2_hold1", {16'h0, irq_signal}, 32'h0008);
        tick();
        chk("t2_hold2", {16'h0, irq_signal}, 32'h0008);
        tick();
        chk("t2_clr", {16'h0, irq_signal}, 32'h0);
        tick_en = 1'b0;

        // 3: M-external through synchronizer
        wr(2'd1, 32'h30);
        ext_irq_m = 1'b1;
        tick(N);
        chk("t3_rise_early", {16'h0, irq_signal}, 32'h0);
        tick();
        chk("t3_rise", {16'h0, irq_signal}, 32'h0020);
        ext_irq_m = 1'b0;
        tick(N);
        chk("t3_fall_early", {16'h0, irq_signal}, 32'h0020);
        tick();
        chk("t3_fall", {16'h0, irq_signal}, 32'h0);

        // 4: several sources, then global mask
        wr(2'd1, 32'h31);
        wr(2'd0, 32'h01);
        ext_irq_s = 1'b1;
        ext_irq_m = 1'b1;
        tick(4);
        chk("t4_irq", {16'h0, irq_signal}, 32'h0031);
        global_en = 1'b0;
        tick();
        chk("t4_mask", {16'h0, irq_signal}, 32'h0);
        chk("t4_valid", {31'h0, irq_valid}, 32'h0);
        chk("t4_rd", csr_rdata, 32'h31);

        // 6: reset while active
        ext_irq_s = 1'b0;
        ext_irq_m = 1'b0;
        global_en = 1'b1;
        wr(2'd1, 32'h03);
        wr(2'd0, 32'h03);
        tick(4);
        chk("t6_irq", {16'h0, irq_signal}, 32'h0003);
        reset = 1'b0;
        #1;
        chk("t6_irq_rst", {16'h0, irq_signal}, 32'h0);
        chk("t6_pend_rst", csr_rdata, 32'h0);
        csr_sel = 2'd1;
        #1 chk("t6_en_rst", csr_rdata, 32'h0);
        csr_sel = 2'd0;
        tick(2);
        reset = 1'b1;
        tick();
        csr_sel = 2'd2;
        #1 chk("t6_mcmp", csr_rdata, 32'hFFFF_FFFF);
        csr_sel = 2'd0;

        // 5: wrap on the narrow instance, stimecmp = all ones minus one
        w2_we = 1'b1;
        w2_sel = 2'd3;
        w2_wd = 8'hFE;
        tick();
        w2_we = 1'b0;
        w2_sel = 2'd0;
        w2_ten = 1'b1;
        for (i = 0; i < 300 && w2_mtime != 8'hFE; i++) tick();
        chk("t5_at_fe", {24'h0, w2_mtime}, 32'hFE);
        chk("t5_p_fd", {31'h0, w2_rd[2]}, 32'h0);
        tick();
        chk("t5_at_ff", {24'h0, w2_mtime}, 32'hFF);
        chk("t5_p_fe", {31'h0, w2_rd[2]}, 32'h1);
        tick();
        chk("t5_at_00", {24'h0, w2_mtime}, 32'h00);
        chk("t5_p_ff", {31'h0, w2_rd[2]}, 32'h1);
        tick();
        chk("t5_p_00", {31'h0, w2_rd[2]}, 32'h0);
        w2_ten = 1'b0;

        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
